neuron_in_packer: RTL and testbench
===================================

# neuron_in_packer

Upstream feeder for the 14-input output neuron. It accepts a serial stream of 17-bit activations from the hidden layer through a valid/ready handshake and packs them into the 14-slot `x` bus. It also holds a locally writable 14-slot weight bank for the `w` bus. After a complete vector is packed it asserts `ce` for the neuron's fixed pipeline latency, then captures the neuron's 17-bit sigmoid output and presents it downstream on a valid/ready port.

## Interface
- `N_IN`, 14, number of neuron inputs (slots)
- `DW`, 17, width of activations, weights and result
- `LAT`, 8, cycles from the `x`/`w` bus becoming stable to a valid `y_in`
- `clk` in 1: single clock, all logic on its rising edge
- `rst` in 1: reset, synchronous, active-high
- `s_valid` in 1: input sample valid
- `s_ready` out 1: packer can accept a sample
- `s_data` in DW: activation sample
- `s_last` in 1: marks the final sample of a vector
- `wr_en` in 1: weight write strobe
- `wr_addr` in 4: weight slot index, 0..N_IN-1
- `wr_data` in DW: weight value
- `wr_err` out 1: sticky flag; a weight write was dropped
- `x_out` out DW*N_IN: packed activations; slot i occupies bits [DW*(i+1)-1:DW*i]
- `w_out` out DW*N_IN: packed weights, same slot layout
- `ce_out` out 1: enable for the neuron's adder tree
- `y_in` in DW: neuron output
- `m_valid` out 1: result valid
- `m_ready` in 1: downstream accepts the result
- `m_data` out DW: captured neuron result

## Operation
- FSM states: FILL, WAIT, HOLD. Reset state is FILL with slot index 0.
- FILL:
  - `s_ready`=1.
  - On each `s_valid&&s_ready`, write `s_data` to slot[idx] and increment idx.
  - Go to WAIT when the handshake lands on idx==N_IN-1, or on `s_last` (see Configuration).
- WAIT:
  - `ce_out`=1, `s_ready`=0. `x_out` and `w_out` are frozen.
  - A latency counter counts 0..LAT-1.
  - At count LAT-1, capture `y_in` into `m_data`, set `m_valid`, and go to HOLD.
- HOLD:
  - `m_valid`=1 until `m_valid&&m_ready`.
  - On that handshake, clear all x slots to 0, set idx=0, and go to FILL.
  - `m_data` keeps its value until the next capture.
- Weights:
  - `wr_en` in FILL writes `wr_data` to wbank[`wr_addr`].
  - `wr_en` in WAIT or HOLD is dropped and sets `wr_err`.
  - `wr_addr`>=N_IN is always dropped and sets `wr_err`.
  - `wr_err` clears only on `rst`.
- Weight bank contents survive everything except `rst`.
- No arithmetic in this block. Data passes bit-exact; no sign extension or scaling.

## Timing
- Reset values, all driven while `rst`=1:
  - `s_ready`=0, `m_valid`=0, `ce_out`=0, `wr_err`=0.
  - `m_data`=0, `x_out`=0, `w_out`=0.
- `s_ready`=1 from the first cycle after `rst` deasserts.
- Latency: last sample accepted in cycle T.
  - `ce_out` is high in cycles T+1..T+LAT.
  - `m_valid` rises in cycle T+LAT+1.
- Back-to-back operation: HOLD handshake in cycle H puts the block in FILL, `s_ready`=1 in cycle H+1. Vector period minimum is N_IN+LAT+1 cycles with `m_ready` tied high.
- `rst` in mid-WAIT or mid-HOLD:
  - Abandons the result (`m_valid` drops the next cycle).
  - Clears the x slots and the weight bank.
- A weight write to slot k in cycle T appears on `w_out` in cycle T+1.
- No combinational path from `m_ready` or `s_valid` to any output.

## Configuration
- Macro: `NEURON_IN_SHORT_VEC_EN`.
- Defined:
  - `s_last` on a handshake with idx<N_IN-1 ends FILL early.
  - The remaining slots stay 0 (zero-padding), since slots are cleared on every return to FILL.
- Undefined:
  - `s_last` is ignored.
  - Exactly N_IN samples are always taken per vector.

## Structure
- Shared package `nn_pkg` holds:
  - The `DW` and `N_IN` defaults.
  - A `neuron_lat` constant, which must equal the neuron pipeline depth (multiplier + 4 adder stages + LUT).
  - The FSM state typedef (FILL/WAIT/HOLD).
- One sub-module, `wbank`: a 14x17 register file with a write port and a flattened parallel read bus. It also holds the address-range check feeding `wr_err`.

## Test plan
- Write weights 1..14 to slots 0..13, then stream samples 0x00100..0x0010D → `x_out`/`w_out` slots match. `ce_out` is high for exactly 8 cycles. `m_valid` rises in cycle T+9 with `m_data` equal to `y_in` sampled at T+8.
- Hold `m_ready`=0 for 20 cycles in HOLD → `m_valid` and `m_data` stay stable and `s_ready`=0 throughout. Release → FILL next cycle with all x slots 0.
- `wr_en` during WAIT, and `wr_addr`=15 during FILL → both writes dropped, `w_out` unchanged, `wr_err`=1 until `rst`.
- With `NEURON_IN_SHORT_VEC_EN`: 5 samples with `s_last` on the 5th → slots 5..13 are 0 and `ce_out` starts the next cycle. Without the macro: the same stimulus keeps `s_ready`=1 until the 14th sample.
- Assert `rst` 3 cycles into WAIT → the next cycle shows `ce_out`=0, `m_valid`=0, x and w cleared, and `s_ready`=1 the cycle after `rst` drops.
- Random `s_valid`/`m_ready` gaps over 50 vectors → the result sequence matches a reference model; no sample is lost or duplicated.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: sizes, neuron pipeline depth and packer FSM state shared by the
// neuron input packer and its weight bank.
package nn_pkg;

    localparam int N_IN_DEF = 14;
    localparam int DW_DEF   = 17;

    // Stage counts of the downstream neuron; neuron_lat is their sum.
    localparam int MUL_STAGES = 2;
    localparam int ADD_STAGES = 4;
    localparam int LUT_STAGES = 2;
    localparam int neuron_lat = MUL_STAGES + ADD_STAGES + LUT_STAGES;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } pk_state_e;

endpackage

// File: rtl/wbank.sv
// wbank: N_IN x DW weight register file with a flattened read bus and a
// sticky error flag for writes that are out of range or arrive while closed.
module wbank
    import nn_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               open_i,
    input  logic               wr_en_i,
    input  logic [3:0]         wr_addr_i,
    input  logic [DW-1:0]      wr_data_i,
    output logic [DW*N_IN-1:0] rd_o,
    output logic               err_o
);

    logic [DW-1:0] bank_q [N_IN];
    logic          err_q;
    logic          addr_ok;

    assign addr_ok = (int'(wr_addr_i) < N_IN);

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q <= '{default: '0};
            err_q  <= 1'b0;
        end else if (wr_en_i) begin
            if (open_i && addr_ok) begin
                bank_q[wr_addr_i] <= wr_data_i;
            end else begin
                err_q <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_rd
        assign rd_o[DW*i +: DW] = bank_q[i];
    end

    assign err_o = err_q;

endmodule

// File: rtl/neuron_in_packer.sv
// neuron_in_packer: packs a serial activation stream into the neuron x bus,
// runs the fixed-latency neuron, returns its result. Option: NEURON_IN_SHORT_VEC_EN.
module neuron_in_packer
    import nn_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int DW   = DW_DEF,
    parameter int LAT  = neuron_lat
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DW-1:0]      s_data,
    input  logic               s_last,
    input  logic               wr_en,
    input  logic [3:0]         wr_addr,
    input  logic [DW-1:0]      wr_data,
    output logic               wr_err,
    output logic [DW*N_IN-1:0] x_out,
    output logic [DW*N_IN-1:0] w_out,
    output logic               ce_out,
    input  logic [DW-1:0]      y_in,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DW-1:0]      m_data
);

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N_IN - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

    pk_state_e     state_q;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] x_q [N_IN];
    logic [DW-1:0] m_data_q;
    logic          m_valid_q;
    logic          ce_q;

    logic take;
    logic last_hit;
    logic fill_end;

    // s_ready is state-decoded only; it never looks at s_valid.
    assign s_ready = (state_q == FILL) && !rst;
    assign take    = s_valid && s_ready;

`ifdef NEURON_IN_SHORT_VEC_EN
    assign last_hit = s_last;
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign last_hit      = 1'b0;
`endif

    assign fill_end = (idx_q == IDX_LAST) || last_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            idx_q     <= '0;
            cnt_q     <= '0;
            x_q       <= '{default: '0};
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            ce_q      <= 1'b0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (take) begin
                        x_q[idx_q] <= s_data;
                        idx_q      <= idx_q + 1'b1;
                        if (fill_end) begin
                            state_q <= WAIT;
                            cnt_q   <= '0;
                            ce_q    <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        m_data_q  <= y_in;
                        m_valid_q <= 1'b1;
                        ce_q      <= 1'b0;
                        state_q   <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    // Clearing x here gives zero-padding for short vectors.
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        x_q       <= '{default: '0};
                        idx_q     <= '0;
                        state_q   <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_x
        assign x_out[DW*i +: DW] = x_q[i];
    end

    wbank #(
        .N_IN (N_IN),
        .DW   (DW)
    ) u_wbank (
        .clk       (clk),
        .rst       (rst),
        .open_i    (state_q == FILL),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_o      (w_out),
        .err_o     (wr_err)
    );

    assign ce_out  = ce_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_neuron_in_packer.sv
// tb_neuron_in_packer: directed vectors plus a randomized-gap stream
// checked against a packing/latency reference for neuron_in_packer.
module tb_neuron_in_packer;

    localparam int N = 14;
    localparam int W = 17;
    localparam int L = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [W-1:0]   s_data = '0;
    logic           s_last = 1'b0;
    logic           wr_en = 1'b0;
    logic [3:0]     wr_addr = '0;
    logic [W-1:0]   wr_data = '0;
    logic           wr_err;
    logic [W*N-1:0] x_out;
    logic [W*N-1:0] w_out;
    logic           ce_out;
    logic [W-1:0]   y_in;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [W-1:0]   m_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t_last = 0;
    int widx = 0;
    logic [W*N-1:0] xm = '0;
    logic [W*N-1:0] wexp = '0;
    logic [W-1:0]   exp1;
    logic [W-1:0]   expq [$];

    neuron_in_packer dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_err  (wr_err),
        .x_out   (x_out),
        .w_out   (w_out),
        .ce_out  (ce_out),
        .y_in    (y_in),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Order-sensitive fold of a packed x vector.
    function automatic logic [W-1:0] fold(input logic [W*N-1:0] v);
        logic [W-1:0] a = '0;
        for (int i = 0; i < N; i++)
            a = a + W'(32'(v[W*i +: W]) * (i + 1));
        return a;
    endfunction

    function automatic logic [W-1:0] slot(input logic [W*N-1:0] v, input int i);
        return v[W*i +: W];
    endfunction

    // Neuron stand-in: output depends on x and on the cycle it is sampled.
    assign y_in = fold(x_out) + W'(cyc);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input logic last);
        logic done = 1'b0;
        s_valid = 1'b1;
        s_data = d;
        s_last = last;
        for (int k = 0; k < 200 && !done; k++) begin
            if (s_ready) begin
                t_last = cyc;
                xm[W*widx +: W] = d;
                widx++;
                done = 1'b1;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic drain(input logic [W-1:0] exp);
        logic done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            if (m_valid) begin
                m_ready = 1'b1;
                chk("m_data", m_data, exp);
                done = 1'b1;
            end
            @(negedge clk);
        end
        m_ready = 1'b0;
        if (!done) chk("drain_timeout", 0, 1);
        xm = '0;
        widx = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ce_n;
        int first;

        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_ce", ce_out, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_x", |x_out, 0);
        chk("rst_w", |w_out, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("s_ready_after_rst", s_ready, 1);

        for (int i = 0; i < N; i++) begin
            wr(4'(i), W'(i + 1));
            wexp[W*i +: W] = W'(i + 1);
            chk("w_slot_next_cycle", slot(w_out, i), W'(i + 1));
        end

        // Full vector, ce window, capture cycle, write dropped in WAIT.
        for (int i = 0; i < N; i++) send(W'(17'h00100 + i), 1'b0);
        exp1 = fold(xm) + W'(t_last + L);
        ce_n = 0;
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            if (ce_out) ce_n++;
            if (m_valid && first < 0) first = cyc;
            wr_en = (k == 2);
            wr_addr = 4'd3;
            wr_data = 17'h1FFFF;
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("ce_cycles", ce_n, L);
        chk("m_valid_rise", first, t_last + L + 1);
        chk("m_data_capture", m_data, exp1);
        chk("x_slot0", slot(x_out, 0), 17'h00100);
        chk("x_slot13", slot(x_out, 13), 17'h0010D);
        chk("wr_err_wait", wr_err, 1);
        chk("w_after_wait_wr", w_out == wexp, 1);

        // Backpressure in HOLD.
        for (int k = 0; k < 20; k++) begin
            chk("hold_m_valid", m_valid, 1);
            chk("hold_m_data", m_data, exp1);
            chk("hold_s_ready", s_ready, 0);
            @(negedge clk);
        end
        drain(exp1);
        chk("fill_after_hold", s_ready, 1);
        chk("m_valid_drop", m_valid, 0);
        chk("x_cleared", |x_out, 0);

        // Five samples with s_last on the fifth.
        for (int i = 0; i < 5; i++) send(W'(17'h00200 + i), i == 4);
`ifdef NEURON_IN_SHORT_VEC_EN
        chk("short_s_ready", s_ready, 0);
        chk("short_ce", ce_out, 1);
        chk("short_slot4", slot(x_out, 4), 17'h00204);
        chk("short_pad", |x_out[W*N-1:W*5], 0);
`else
        for (int i = 5; i < N; i++) begin
            chk("long_s_ready", s_ready, 1);
            send(W'(17'h00200 + i), 1'b0);
        end
        chk("long_done", s_ready, 0);
        chk("long_ce", ce_out, 1);
`endif
        drain(fold(xm) + W'(t_last + L));

        // Reset three cycles into WAIT.
        for (int i = 0; i < N; i++) send(W'(17'h00300 + i), 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rw_ce", ce_out, 0);
        chk("rw_m_valid", m_valid, 0);
        chk("rw_x", |x_out, 0);
        chk("rw_w", |w_out, 0);
        chk("rw_wr_err", wr_err, 0);
        chk("rw_s_ready", s_ready, 0);
        rst = 1'b0;
        xm = '0;
        widx = 0;
        @(negedge clk);
        chk("rw_s_ready_after", s_ready, 1);

        // Out-of-range write in FILL.
        wexp = '0;
        for (int i = 0; i < N; i++) begin
            wr(4'(i), W'(17'h10000 | i));
            wexp[W*i +: W] = W'(17'h10000 | i);
        end
        chk("wr_err_clean", wr_err, 0);
        wr(4'd15, 17'h1ABCD);
        chk("wr_err_range", wr_err, 1);
        chk("w_after_range_wr", w_out == wexp, 1);

        // Random handshake gaps over 50 vectors.
        fork
            begin : prod
                for (int v = 0; v < 50; v++) begin
                    for (int i = 0; i < N; i++) begin
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                        send(W'($urandom), 1'b0);
                    end
                    expq.push_back(fold(xm) + W'(t_last + L));
                    xm = '0;
                    widx = 0;
                end
            end
            begin : cons
                int got;
                got = 0;
                for (int k = 0; k < 20000 && got < 50; k++) begin
                    m_ready = 1'($urandom_range(0, 1));
                    if (m_valid && m_ready) begin
                        if (expq.size() == 0) chk("rnd_unexpected", 0, 1);
                        else chk("rnd_result", m_data, expq.pop_front());
                        got++;
                    end
                    @(negedge clk);
                end
                m_ready = 1'b0;
                chk("rnd_count", 64'(got), 50);
            end
        join
        chk("rnd_leftover", expq.size(), 0);
        chk("wr_err_sticky", wr_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
